// File: rtl/pdp8_operate_sequencer_pkg.sv
// Shared types and instruction field positions for the PDP-8 operate-group sequencer.
// Everything here is independent of the accumulator width.
package pdp8_operate_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_CMP,
        ST_INC,
        ST_ROT,
        ST_ROT2,
        ST_G2,
        ST_G3,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        GRP_1 = 2'd0,
        GRP_2 = 2'd1,
        GRP_3 = 2'd2
    } grp_t;

    typedef enum logic [2:0] {
        ROT_NONE,
        ROT_R1,
        ROT_R2,
        ROT_L1,
        ROT_L2,
        ROT_BSW
    } rot_op_t;

    localparam int unsigned OPR_GRP_BIT = 8;
    localparam int unsigned OPR_G3_BIT  = 0;

    localparam int unsigned G1_CLA = 7;
    localparam int unsigned G1_CLL = 6;
    localparam int unsigned G1_CMA = 5;
    localparam int unsigned G1_CML = 4;
    localparam int unsigned G1_RAR = 3;
    localparam int unsigned G1_RAL = 2;
    localparam int unsigned G1_BSW = 1;
    localparam int unsigned G1_IAC = 0;

    localparam int unsigned G2_CLA = 7;
    localparam int unsigned G2_SMA = 6;
    localparam int unsigned G2_SZA = 5;
    localparam int unsigned G2_SNL = 4;
    localparam int unsigned G2_REV = 3;
    localparam int unsigned G2_OSR = 2;
    localparam int unsigned G2_HLT = 1;

    localparam int unsigned G3_CLA = 7;
    localparam int unsigned G3_MQA = 6;
    localparam int unsigned G3_MQL = 4;

    function automatic grp_t decode_group(input logic [8:0] op);
        if (!op[OPR_GRP_BIT]) return GRP_1;
        if (op[OPR_G3_BIT])   return GRP_3;
        return GRP_2;
    endfunction

endpackage

// File: rtl/pdp8_link_rotator.sv
// Combinational rotate-by-1/2 and half-word swap of the 13-bit {L,AC} pair.
// Byte swap leaves the link bit in place.
module pdp8_link_rotator
    import pdp8_operate_sequencer_pkg::*;
#(
    parameter int unsigned WORD_W = 12
)(
    input  rot_op_t           op,
    input  logic [WORD_W:0]   link_ac,
    output logic [WORD_W:0]   result
);

    localparam int unsigned HALF = WORD_W / 2;

    always_comb begin
        result = link_ac;
        case (op)
            ROT_R1:  result = {link_ac[0], link_ac[WORD_W:1]};
            ROT_R2:  result = {link_ac[1:0], link_ac[WORD_W:2]};
            ROT_L1:  result = {link_ac[WORD_W-1:0], link_ac[WORD_W]};
            ROT_L2:  result = {link_ac[WORD_W-2:0], link_ac[WORD_W:WORD_W-1]};
            ROT_BSW: result = {link_ac[WORD_W], link_ac[HALF-1:0], link_ac[WORD_W-1:HALF]};
            default: result = link_ac;
        endcase
    end

endmodule

// File: rtl/pdp8_operate_sequencer.sv
// Multi-cycle sequencer for PDP-8 operate instructions (groups 1, 2 and 3).
// Group 1 steps through one micro-operation per cycle; groups 2 and 3 finish in one working state.
module pdp8_operate_sequencer
    import pdp8_operate_sequencer_pkg::*;
#(
    parameter int unsigned WORD_W   = 12,
    parameter bit          FAST_ROT = 1'b0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [8:0]        instr,
    input  logic [WORD_W-1:0] ac_in,
    input  logic              l_in,
    input  logic [WORD_W-1:0] sr_in,
    output logic [WORD_W-1:0] ac_out,
    output logic              l_out,
    output logic [WORD_W-1:0] mq_out,
    output logic              skip,
    output logic              halt,
    output logic              illegal,
    output logic              busy,
    output logic              done
);

    state_t            state, state_nxt;
    logic [8:0]        ir;
    logic [WORD_W-1:0] ac, mq, sr;
    logic              l, skip_q, halt_q, ill_q;

    logic              rar, ral, bsw, rot_twice;
    rot_op_t           rot_op;
    logic [WORD_W:0]   rot_result, inc_sum;

    logic              ac_neg, ac_zero, g2_skip;
    logic [WORD_W-1:0] g2_ac, g3_cla, g3_ac, g3_mq;

    assign rar       = ir[G1_RAR];
    assign ral       = ir[G1_RAL];
    assign bsw       = ir[G1_BSW];
    assign rot_twice = bsw & (rar | ral) & ~FAST_ROT;
    assign inc_sum   = {l, ac} + {{WORD_W{1'b0}}, 1'b1};

    // A doubled rotate is split over ROT and ROT2 unless FAST_ROT does it in one step.
    always_comb begin
        rot_op = ROT_NONE;
        if (state == ST_ROT) begin
            if (rar && !ral)
                rot_op = (bsw && FAST_ROT) ? ROT_R2 : ROT_R1;
            else if (ral && !rar)
                rot_op = (bsw && FAST_ROT) ? ROT_L2 : ROT_L1;
            else if (bsw && !rar && !ral)
                rot_op = ROT_BSW;
        end else if (state == ST_ROT2) begin
            if (rar && !ral)
                rot_op = ROT_R1;
            else if (ral && !rar)
                rot_op = ROT_L1;
        end
    end

    pdp8_link_rotator #(.WORD_W(WORD_W)) u_rotator (
        .op      (rot_op),
        .link_ac ({l, ac}),
        .result  (rot_result)
    );

    assign ac_neg  = ac[WORD_W-1];
    assign ac_zero = (ac == '0);

    always_comb begin
        if (!ir[G2_REV])
            g2_skip = (ir[G2_SMA] & ac_neg) | (ir[G2_SZA] & ac_zero) | (ir[G2_SNL] & l);
        else
            g2_skip = (~ir[G2_SMA] | ~ac_neg) & (~ir[G2_SZA] | ~ac_zero) & (~ir[G2_SNL] | ~l);
        g2_ac = ir[G2_CLA] ? '0 : ac;
        if (ir[G2_OSR])
            g2_ac = g2_ac | sr;
    end

    always_comb begin
        g3_cla = ir[G3_CLA] ? '0 : ac;
        g3_ac  = g3_cla;
        g3_mq  = mq;
        if (ir[G3_MQA] && ir[G3_MQL]) begin
            g3_ac = mq;
            g3_mq = g3_cla;
        end else if (ir[G3_MQA]) begin
            g3_ac = g3_cla | mq;
        end else if (ir[G3_MQL]) begin
            g3_mq = g3_cla;
            g3_ac = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (decode_group(instr))
                        GRP_1:   state_nxt = ST_CLR;
                        GRP_2:   state_nxt = ST_G2;
                        default: state_nxt = ST_G3;
                    endcase
                end
            end
            ST_CLR:  state_nxt = ST_CMP;
            ST_CMP:  state_nxt = ST_INC;
            ST_INC:  state_nxt = ST_ROT;
            ST_ROT:  state_nxt = rot_twice ? ST_ROT2 : ST_DONE;
            ST_ROT2: state_nxt = ST_DONE;
            ST_G2:   state_nxt = ST_DONE;
            ST_G3:   state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir     <= '0;
            ac     <= '0;
            l      <= 1'b0;
            sr     <= '0;
            mq     <= '0;
            skip_q <= 1'b0;
            halt_q <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ir     <= instr;
                        ac     <= ac_in;
                        l      <= l_in;
                        sr     <= sr_in;
                        skip_q <= 1'b0;
                        halt_q <= 1'b0;
                        ill_q  <= 1'b0;
                    end
                end
                ST_CLR: begin
                    if (ir[G1_CLA]) ac <= '0;
                    if (ir[G1_CLL]) l  <= 1'b0;
                end
                ST_CMP: begin
                    if (ir[G1_CMA]) ac <= ~ac;
                    if (ir[G1_CML]) l  <= ~l;
                end
                ST_INC: begin
                    if (ir[G1_IAC]) {l, ac} <= inc_sum;
                end
                ST_ROT: begin
                    {l, ac} <= rot_result;
                    if (rar && ral) ill_q <= 1'b1;
                end
                ST_ROT2: {l, ac} <= rot_result;
                ST_G2: begin
                    ac     <= g2_ac;
                    skip_q <= g2_skip;
                    halt_q <= ir[G2_HLT];
                end
                ST_G3: begin
                    ac <= g3_ac;
                    mq <= g3_mq;
                end
                default: ;
            endcase
        end
    end

    assign ac_out  = ac;
    assign l_out   = l;
    assign mq_out  = mq;
    assign skip    = skip_q;
    assign halt    = halt_q;
    assign illegal = ill_q;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_pdp8_operate_sequencer.sv
// Bench for pdp8_operate_sequencer: a slow-rotate and a fast-rotate instance share stimulus
// and are compared every cycle against an arithmetic model of the operate instructions.
module tb_pdp8_operate_sequencer;

    localparam int unsigned W = 12;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [8:0]   instr = '0;
    logic [W-1:0] ac_in = '0;
    logic         l_in  = 1'b0;
    logic [W-1:0] sr_in = '0;

    logic [W-1:0] ac_o [2];
    logic [W-1:0] mq_o [2];
    logic         l_o [2];
    logic         skip_o [2];
    logic         halt_o [2];
    logic         ill_o [2];
    logic         busy_o [2];
    logic         done_o [2];

    always #5 clk = ~clk;

    pdp8_operate_sequencer #(.WORD_W(W), .FAST_ROT(1'b0)) dut_slow (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .ac_in(ac_in), .l_in(l_in),
        .sr_in(sr_in), .ac_out(ac_o[0]), .l_out(l_o[0]), .mq_out(mq_o[0]), .skip(skip_o[0]),
        .halt(halt_o[0]), .illegal(ill_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    pdp8_operate_sequencer #(.WORD_W(W), .FAST_ROT(1'b1)) dut_fast (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .ac_in(ac_in), .l_in(l_in),
        .sr_in(sr_in), .ac_out(ac_o[1]), .l_out(l_o[1]), .mq_out(mq_o[1]), .skip(skip_o[1]),
        .halt(halt_o[1]), .illegal(ill_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    typedef struct packed {
        logic [11:0] ac;
        logic        l;
        logic [11:0] mq;
        logic        skip;
        logic        halt;
        logic        ill;
        int          lat;
    } res_t;

    int          checks_total  = 0;
    int          checks_passed = 0;
    int          edge_cnt      = 0;
    int          start_ref     = -1000;
    bit          in_reset      = 1'b1;
    res_t        exp_r [2];
    logic [11:0] mq_prev [2];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int d, input int act, input int expv);
        checks_total++;
        if (act == expv)
            checks_passed++;
        else
            $display("FAIL %s dut%0d: got %0o, expected %0o (t=%0t)", name, d, act, expv, $time);
    endtask

    // Behavioural model: {L,AC} treated as a 13-bit integer.
    function automatic res_t model(input logic [8:0] ins, input int ac_i, input int l_i,
                                   input int sr_i, input int mq_i, input bit fast);
        res_t r;
        int   ac, l, mq, v, n;
        bit   neg, zero;
        r  = '0;
        ac = ac_i;
        l  = l_i;
        mq = mq_i;
        if (ins[8] == 1'b0) begin
            if (ins[7]) ac = 0;
            if (ins[6]) l = 0;
            if (ins[5]) ac = 4095 - ac;
            if (ins[4]) l = 1 - l;
            if (ins[0]) begin
                v  = (l * 4096 + ac + 1) % 8192;
                l  = v / 4096;
                ac = v % 4096;
            end
            r.lat = (ins[1] && (ins[3] || ins[2]) && !fast) ? 6 : 5;
            if (ins[3] && ins[2]) begin
                r.ill = 1'b1;
            end else if (ins[3] || ins[2]) begin
                n = ins[1] ? 2 : 1;
                v = l * 4096 + ac;
                for (int i = 0; i < n; i++)
                    v = ins[3] ? (v / 2 + (v % 2) * 4096) : ((v * 2) % 8192 + v / 4096);
                l  = v / 4096;
                ac = v % 4096;
            end else if (ins[1]) begin
                ac = (ac % 64) * 64 + ac / 64;
            end
        end else if (ins[0] == 1'b0) begin
            neg  = (ac >= 2048);
            zero = (ac == 0);
            if (!ins[3])
                r.skip = (ins[6] && neg) || (ins[5] && zero) || (ins[4] && l == 1);
            else
                r.skip = (!ins[6] || !neg) && (!ins[5] || !zero) && (!ins[4] || l == 0);
            if (ins[7]) ac = 0;
            if (ins[2]) ac = ac | sr_i;
            r.halt = ins[1];
            r.lat  = 2;
        end else begin
            if (ins[7]) ac = 0;
            if (ins[6] && ins[4]) begin
                v  = ac;
                ac = mq;
                mq = v;
            end else if (ins[6]) begin
                ac = ac | mq;
            end else if (ins[4]) begin
                mq = ac;
                ac = 0;
            end
            r.lat = 2;
        end
        r.ac = ac[11:0];
        r.l  = l[0];
        r.mq = mq[11:0];
        return r;
    endfunction

    always @(negedge clk) begin : cmp
        int k;
        k = edge_cnt - start_ref;
        for (int d = 0; d < 2; d++) begin
            if (in_reset) begin
                chk("reset_busy", d, busy_o[d], 0);
                chk("reset_done", d, done_o[d], 0);
                chk("reset_ac", d, ac_o[d], 0);
                chk("reset_l", d, l_o[d], 0);
                chk("reset_mq", d, mq_o[d], 0);
                chk("reset_flags", d, {skip_o[d], halt_o[d], ill_o[d]}, 0);
            end else if (k >= 1) begin
                chk("busy", d, busy_o[d], (k <= exp_r[d].lat) ? 1 : 0);
                chk("done", d, done_o[d], (k == exp_r[d].lat) ? 1 : 0);
                if (k >= exp_r[d].lat) begin
                    chk("ac", d, ac_o[d], exp_r[d].ac);
                    chk("l", d, l_o[d], exp_r[d].l);
                    chk("mq", d, mq_o[d], exp_r[d].mq);
                    chk("skip", d, skip_o[d], exp_r[d].skip);
                    chk("halt", d, halt_o[d], exp_r[d].halt);
                    chk("illegal", d, ill_o[d], exp_r[d].ill);
                end else begin
                    chk("mq_hold", d, mq_o[d], mq_prev[d]);
                end
            end
        end
    end

    task automatic start_op(input logic [8:0] ins, input logic [11:0] a, input logic li,
                            input logic [11:0] s);
        for (int d = 0; d < 2; d++) begin
            mq_prev[d] = exp_r[d].mq;
            exp_r[d]   = model(ins, a, li, s, exp_r[d].mq, d == 1);
        end
        instr     = ins;
        ac_in     = a;
        l_in      = li;
        sr_in     = s;
        start     = 1'b1;
        start_ref = edge_cnt;
    endtask

    // Runs until both instances are idle again; optionally pulses start while they are busy.
    task automatic finish_op(input bit spur);
        int lmax, lmin;
        lmax = (exp_r[0].lat > exp_r[1].lat) ? exp_r[0].lat : exp_r[1].lat;
        lmin = (exp_r[0].lat < exp_r[1].lat) ? exp_r[0].lat : exp_r[1].lat;
        @(negedge clk);
        start = 1'b0;
        while (edge_cnt - start_ref <= lmax) begin
            instr = 9'($urandom);
            ac_in = 12'($urandom);
            l_in  = 1'($urandom);
            sr_in = 12'($urandom);
            start = spur && (edge_cnt - start_ref <= lmin) && ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic pin(input string name, input int act, input int expv);
        chk(name, 0, act, expv);
    endtask

    initial begin
        res_t p;
        for (int d = 0; d < 2; d++) begin
            exp_r[d]   = '0;
            mq_prev[d] = '0;
        end

        p = model(9'o301, 12'o5555, 1, 0, 0, 1'b0);
        pin("pin_301_ac", p.ac, 12'o0001);
        pin("pin_301_l", p.l, 0);
        pin("pin_301_lat", p.lat, 5);
        p = model(9'o041, 12'o0000, 0, 0, 0, 1'b0);
        pin("pin_041_ac", p.ac, 12'o0000);
        pin("pin_041_l", p.l, 1);
        p = model(9'o006, 12'o4001, 0, 0, 0, 1'b0);
        pin("pin_006_ac", p.ac, 12'o0005);
        pin("pin_006_lat", p.lat, 6);
        p = model(9'o006, 12'o4001, 0, 0, 0, 1'b1);
        pin("pin_006f_ac", p.ac, 12'o0005);
        pin("pin_006f_lat", p.lat, 5);
        p = model(9'o640, 12'o0000, 0, 0, 0, 1'b0);
        pin("pin_640_skip", p.skip, 1);
        p = model(9'o410, 12'o1234, 1, 0, 0, 1'b0);
        pin("pin_410_skip", p.skip, 1);
        p = model(9'o014, 12'o1234, 0, 0, 0, 1'b0);
        pin("pin_014_ill", p.ill, 1);
        pin("pin_014_ac", p.ac, 12'o1234);
        p = model(9'o501, 12'o0070, 0, 0, 12'o1234, 1'b0);
        pin("pin_501_ac", p.ac, 12'o1274);
        pin("pin_501_mq", p.mq, 12'o1234);

        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_ref = edge_cnt - 1000;
        rst       = 1'b0;
        in_reset  = 1'b0;

        start_op(9'o301, 12'o5555, 1'b1, 12'o0000); finish_op(1'b0);
        start_op(9'o041, 12'o0000, 1'b0, 12'o0000); finish_op(1'b0);
        start_op(9'o006, 12'o4001, 1'b0, 12'o0000); finish_op(1'b1);
        start_op(9'o640, 12'o0000, 1'b0, 12'o0000); finish_op(1'b0);
        start_op(9'o410, 12'o7777, 1'b1, 12'o0000); finish_op(1'b0);
        start_op(9'o014, 12'o1234, 1'b0, 12'o0000); finish_op(1'b1);
        start_op(9'o016, 12'o1234, 1'b1, 12'o0000); finish_op(1'b0);
        start_op(9'o421, 12'o1234, 1'b0, 12'o0000); finish_op(1'b0);
        start_op(9'o501, 12'o0070, 1'b0, 12'o0000); finish_op(1'b1);
        start_op(9'o406, 12'o0000, 1'b0, 12'o5252); finish_op(1'b0);

        // Reset in the middle of a rotate: outputs must clear without a clock edge.
        start_op(9'o006, 12'o4001, 1'b0, 12'o0000);
        @(negedge clk);
        start = 1'b0;
        while (edge_cnt - start_ref < 4) @(negedge clk);
        #1;
        in_reset = 1'b1;
        rst      = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_busy", d, busy_o[d], 0);
            chk("async_rst_done", d, done_o[d], 0);
            chk("async_rst_mq", d, mq_o[d], 0);
            chk("async_rst_ac", d, ac_o[d], 0);
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            exp_r[d]   = '0;
            mq_prev[d] = '0;
        end
        start_ref = edge_cnt - 1000;
        rst       = 1'b0;
        in_reset  = 1'b0;
        start_op(9'o001, 12'o0000, 1'b0, 12'o0000); finish_op(1'b0);

        repeat (300) begin
            start_op(9'($urandom), 12'($urandom), 1'($urandom), 12'($urandom));
            finish_op(1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/pdp8_operate_sequencer.md
PDP8_OPERATE_SEQUENCER -- requirements
Module: pdp8_operate_sequencer

Interface
REQ-001 SHALL have parameter WORD_W, default 12: accumulator/MQ/switch width; must be even and >= 4.
REQ-002 SHALL have parameter FAST_ROT, default 0: 1 = double rotate (RTR/RTL) in one cycle.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports: start in 1 (request); instr in 9 (operate bits 8:0); ac_in in WORD_W; l_in in 1; sr_in in WORD_W (switch register).
REQ-006 SHALL have ports: ac_out out WORD_W; l_out out 1; mq_out out WORD_W; skip out 1; halt out 1; illegal out 1; busy out 1; done out 1.

Function
REQ-007 SHALL accept start only in IDLE, capturing instr, ac_in, l_in and sr_in; start while busy is ignored.
REQ-008 SHALL decode: instr[8]=0 -> group 1; instr[8]=1 and instr[0]=0 -> group 2; instr[8]=1 and instr[0]=1 -> group 3.
REQ-009 SHALL sequence group 1 through states CLR, CMP, INC, ROT, with ROT2 added when instr[1]=1, RAR or RAL is set and FAST_ROT=0, then DONE; one cycle per state.
REQ-010 CLR: bit7 clears AC, bit6 clears L. CMP: bit5 complements AC, bit4 complements L.
REQ-011 INC: bit0 computes {L,AC}+1 modulo 2^(WORD_W+1), so carry out of AC complements L.
REQ-012 ROT: bit3 rotates {L,AC} right by 1 and bit2 left by 1; bit1 with bit3 or bit2 doubles the rotate; bit1 alone swaps AC upper and lower halves, leaving L unchanged.
REQ-013 bit3 and bit2 both set SHALL perform no rotate and set illegal=1 at DONE.
REQ-014 SHALL run group 2 as states G2, then DONE. Skip is evaluated on the captured AC and L; then CLA (bit7); then OSR (bit2: AC |= sr_in); HLT (bit1) sets halt.
REQ-015 Group 2 with bit3=0 SHALL set skip = (bit6 & AC<0) | (bit5 & AC==0) | (bit4 & L==1).
REQ-016 Group 2 with bit3=1 SHALL set skip = AND over the selected tests of (AC>=0, AC!=0, L==0); with no test selected, skip=1.
REQ-017 SHALL run group 3 as states G3, then DONE. CLA (bit7) applies first. Then: MQA (bit6) and MQL (bit4) together swap AC and MQ; MQA alone does AC |= MQ; MQL alone does MQ=AC then AC=0.
REQ-018 SHALL keep an internal MQ register that persists across instructions; only group 3 modifies it; mq_out reflects it continuously.
REQ-019 SHALL drive busy=1 in every non-IDLE state.
REQ-020 SHALL pulse done for exactly one cycle in DONE and then return to IDLE.
REQ-021 ac_out, l_out, skip, halt and illegal SHALL be valid in the DONE cycle and held until the next accepted start.
REQ-022 SHALL have fixed latency from the start edge to the done cycle: group 1 = 5 cycles, or 6 with ROT2; groups 2 and 3 = 2 cycles.
REQ-023 SHALL clear skip, halt and illegal on each accepted start.

Reset
REQ-024 rst SHALL immediately force IDLE, ac_out=0, l_out=0, MQ=0, skip=0, halt=0, illegal=0, busy=0, done=0, including mid-operation.
REQ-025 After rst deasserts, the first start SHALL be accepted in the next cycle with no residual state.

Structure
REQ-026 The shared package SHALL hold the state enum, group-1/2/3 bit-position constants, and group-encoding constants, all width-independent.
REQ-027 SHALL contain one sub-module, pdp8_link_rotator: combinational rotate-by-1/2 and byte-swap of {L,AC}, parameterised by WORD_W.

Verification (WORD_W=12, octal values)
REQ-028 Group 1: instr 301 (CLA CLL IAC), ac 5555, l=1 -> ac_out 0001, l_out 0, done at cycle 5.
REQ-029 Group 1: instr 041 (CMA IAC), ac 0000, l=0 -> ac_out 0000, l_out 1.
REQ-030 Group 1: instr 006 (RTL), ac 4001, l=0, FAST_ROT=0 -> ac_out 0005, l_out 0, done at cycle 6; with FAST_ROT=1, same result at cycle 5.
REQ-031 Group 2: instr 640 (SZA CLA), ac 0000 -> skip 1, ac_out 0000. Group 2: instr 410 (SKP) -> skip 1. Group 1: instr 014 (RAR+RAL) -> illegal 1, ac unchanged.
REQ-032 Group 3: instr 421 (MQL), ac 1234 -> mq_out 1234, ac_out 0000; then instr 501 (MQA), ac 0070 -> ac_out 1274, mq_out 1234.
REQ-033 Reset: assert rst during ROT of instr 006 -> busy, done and mq_out go 0 with no clock edge; next start of 001 (IAC) on ac 0000 -> ac_out 0001.
